// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e  : controller states (IDLE/RUN/DONE, 2-bit encoding)
//   MODE_ADD / MODE_SUB : values of the 'sub' mode input
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
//   a_d, b_d : digit operands
//   cin      : carry into bit 0
//   s_d      : digit sum
//   cout     : carry out of the top bit
//   c_msb    : carry into the top bit (used for signed overflow)
module addsub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_d[i]  = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]  = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor.
// Operands are latched on an accepted start (ready=1), then DIGIT bits are
// summed per clock, LSB digit first. Results update together with a
// one-cycle done pulse and hold until the next done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, sub : request and mode (0: a+b, 1: a-b), sampled when ready
//   a, b       : WIDTH-bit operands, sampled when ready
//   ready      : high in IDLE only
//   done       : one-cycle pulse when sum/cout/ovf/zero update
//   sum, cout, ovf, zero : result, carry/no-borrow, signed overflow, sum==0
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CNTW = $clog2(NDIG + 1);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;
  logic             last_digit;

  // Operand registers shift right each digit, so the active digit is
  // always in the low DIGIT bits; no variable part-select needed.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (a_q[DIGIT-1:0]),
    .b_d   (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s_d   (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  assign last_digit = (cnt_q == CNTW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = (sub == MODE_SUB);
          cnt_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after NDIG shifts it lines up.
        part_d  = (part_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNTW'(1);
        if (last_digit) begin
          sum_d   = part_d;
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
          zero_d  = (part_d == '0);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a, b;

  logic        rdy4, done4, cout4, ovf4, zero4;
  logic [15:0] sum4;
  logic        rdy16, done16, cout16, ovf16, zero16;
  logic [15:0] sum16;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(rdy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  addsub_serial #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(rdy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the mathematical operands.
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output logic [15:0] es, output logic ec, output logic eo,
                       output logic ez);
    int r;
    if (s) begin
      es = x - y;
      ec = (x >= y);
      r  = int'($signed(x)) - int'($signed(y));
    end else begin
      es = x + y;
      ec = (int'(x) + int'(y)) > 65535;
      r  = int'($signed(x)) + int'($signed(y));
    end
    eo = (r > 32767) || (r < -32768);
    ez = (es == 16'h0000);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_sum4"},  32'(sum4),  32'h0);
    check({tag, "_flg4"},  {28'h0, cout4, ovf4, zero4, done4}, 32'h0);
    check({tag, "_rdy4"},  32'(rdy4),  32'h1);
    check({tag, "_sum16"}, 32'(sum16), 32'h0);
    check({tag, "_flg16"}, {28'h0, cout16, ovf16, zero16, done16}, 32'h0);
    check({tag, "_rdy16"}, 32'(rdy16), 32'h1);
  endtask

  // Called #1 after a rising edge with both units idle.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input bit inject);
    logic [15:0] es, p4, p16;
    logic ec, eo, ez;
    int lat4, lat16;
    model(x, y, s, es, ec, eo, ez);
    p4 = sum4; p16 = sum16;
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat4 = -1; lat16 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (lat4 < 0 && done4 === 1'b1) begin
        lat4 = k;
        check("sum4", 32'(sum4), 32'(es));
        check("flags4", {29'h0, cout4, ovf4, zero4}, {29'h0, ec, eo, ez});
      end else if (lat4 < 0) begin
        check("hold4", 32'(sum4), 32'(p4));
      end else if (k == lat4 + 1) begin
        check("pulse4", 32'(done4), 32'h0);
        check("keep4", 32'(sum4), 32'(es));
      end
      if (lat16 < 0 && done16 === 1'b1) begin
        lat16 = k;
        check("sum16", 32'(sum16), 32'(es));
        check("flags16", {29'h0, cout16, ovf16, zero16}, {29'h0, ec, eo, ez});
      end else if (lat16 >= 0 && k == lat16 + 1) begin
        check("pulse16", 32'(done16), 32'h0);
      end
      // Request while busy, with different operands: must be ignored.
      start = inject && (k == 1);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    end
    start = 1'b0;
    check("lat4", 32'(lat4), 32'd4);
    check("lat16", 32'(lat16), 32'd1);
    check("idle_rdy", {30'h0, rdy4, rdy16}, 32'h3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3;
    check_all_reset("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_reset("post_rst");

    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    check("dir_sum", 32'(sum4), 32'h2201);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("dir_wrap", {15'h0, sum4, cout4, zero4}, {15'h0, 16'h0000, 1'b1, 1'b1});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("dir_ovf", {16'h0, ovf4, cout4}, {16'h0, 1'b1, 1'b0});
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    check("dir_borrow", {15'h0, sum4, cout4}, {15'h0, 16'hFFFE, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    check("dir_subovf", {14'h0, sum4, ovf4, cout4}, {14'h0, 16'h7FFF, 1'b1, 1'b1});
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b1);

    // Abort mid-operation: reset at cycle 2 of RUN.
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_reset("abort");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", {30'h0, done4, done16}, 32'h0);
    end

    for (int n = 0; n < 24; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), n % 5 == 0);
    end
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor. Successor to the fixed 4-bit ripple add/sub.
- Latches WIDTH-bit operands on a start handshake and processes DIGIT bits per clock through a DIGIT-wide ripple digit adder.
- Reports sum, carry/no-borrow, signed overflow and zero with a one-cycle done pulse.
- Sits beside the datapath as a small, area-cheap arithmetic unit for wide operands.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 <= DIGIT <= WIDTH.
- NDIG, WIDTH/DIGIT (derived, localparam), number of digit cycles per operation.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- sub  in  1  mode, sampled with start: 0 gives a+b, 1 gives a-b (a + ~b + 1).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- ready  out  1  high in IDLE only.
- done  out  1  registered one-cycle pulse when results update.
- sum  out  WIDTH  result, held until the next done.
- cout  out  1  carry out of the MSB; in sub mode 1 means no borrow (a >= b unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, digit counter=0, carry=0, operand/partial registers=0, sum=0, cout=0, ovf=0, zero=0, done=0; ready=1 as soon as reset asserts.
- FSM states are IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a, b^{WIDTH{sub}}, sub.
  - carry := sub.
  - cnt := 0.
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: at each edge Ek (k = 1..NDIG):
  - add digit k-1 (bits [k*DIGIT-1:(k-1)*DIGIT], LSB digit first) with the registered carry.
  - store the digit result into the partial register, register the carry out, cnt++.
  - Record the carry into the MSB during the last digit, for ovf.
- At edge E_NDIG:
  - sum/cout/ovf/zero update together from the final digit.
  - done := 1, state := DONE.
- DONE: at the next edge, done := 0, state := IDLE.
- Latency: start sampled at E0; done is high between E_NDIG and E_NDIG+1. Back-to-back throughput is one operation per NDIG+2 cycles.
- Earliest next accept is the edge after done falls.
- start while ready=0 (RUN or DONE) is ignored; no queuing, no effect on the operation in flight.
- Operand inputs a/b/sub may change freely after the accept edge.
- Visible outputs never show partial results; they change only at the done edge.
- NDIG=1 (DIGIT=WIDTH): RUN lasts one cycle; done is high between E1 and E2.
- Wrap-around: the result is modulo 2^WIDTH; cout and ovf carry the lost information.
- Reset mid-operation: operation aborted, no done pulse, outputs return to reset values.

Decomposition:
- Shared package addsub_pkg holds:
  - FSM state enum (IDLE/RUN/DONE, 2-bit encoding).
  - Mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module addsub_digit (parameter DIGIT): combinational ripple of full-adder cells.
  - Inputs: a_d, b_d, cin.
  - Outputs: s_d, cout, c_msb (carry into the top bit).
  - One instance in addsub_serial.
- Counter width is $clog2(NDIG+1).

Test Plan:
- WIDTH=16, DIGIT=4: add 0x1234+0x0FCD -> sum=0x2201, cout=0, ovf=0, zero=0; done exactly 4 edges after accept, pulse width 1 cycle.
- Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0.
- Add 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
- Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
- Sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Start pulsed during RUN with different operands -> ignored; first result unchanged.
- Reset mid-operation:
  - rst_n low at cycle 2 of RUN -> all outputs 0, ready=1, no done.
  - Re-run with DIGIT=16 and WIDTH=16 -> done one edge after accept, same results as above.
